univ_shift_reg: RTL and testbench
=================================

// Module: univ_shift_reg
// PURPOSE
//  Parametrised universal shift register; successor to the fixed 8-bit parallel-load register.
//  Accepts one command at a time: load, clear, hold, or a multi-bit shift/rotate.
//  A shift/rotate of N moves one bit per clock, under a busy/done handshake.
//  Used as the general data-holding and shifting element in later lab datapaths.
// PARAMETERS
//  WIDTH  8  register width in bits, >= 2.
//  CNT_W  derived localparam = $clog2(WIDTH)+1; width of shift amount and counter.
// PORTS
//  i_clk           in   1      single clock; all flops update on the rising edge.
//  i_rst_n         in   1      reset, asynchronous, active-low.
//  i_start         in   1      command strobe; accepted only in IDLE.
//  i_mode          in   3      command opcode (see BEHAVIOUR).
//  i_amount        in   CNT_W  shift/rotate count; values above WIDTH clamp to WIDTH.
//  i_data          in   WIDTH  parallel load value.
//  i_serial        in   1      fill bit for SHL/SHR; sampled on every shift edge.
//  o_busy          out  1      high in SHIFT and DONE states.
//  o_done          out  1      one-cycle pulse when a command completes.
//  o_storedValue   out  WIDTH  register contents.
//  o_serial        out  1      bit shifted/rotated out on the most recent shift edge.
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state=IDLE, o_storedValue=0, o_serial=0, o_done=0,
//    o_busy=0, counter=0. Reset mid-shift aborts the command; no done pulse is issued.
//  Opcodes: 000 HOLD, 001 LOAD, 010 SHL (fill i_serial), 011 SHR (fill i_serial),
//    100 ROL, 101 ROR, 110 SHRA (fill MSB), 111 CLEAR.
//  FSM IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE, i_start=1 at edge k:
//    LOAD/CLEAR: register <= i_data or 0 at edge k; go to DONE.
//    HOLD, or any shift with amount=0: no change; go to DONE.
//    Shift/rotate with amount N>0: latch mode and min(N,WIDTH); go to SHIFT.
//  SHIFT: one single-bit step per edge k+1..k+N.
//    o_serial <= the bit leaving the register. Counter decrements.
//    At the edge where the counter reaches 1, go to DONE.
//  DONE: o_done=1 for exactly one cycle; next edge returns to IDLE.
//  Latency: LOAD/CLEAR/HOLD: done in the cycle after accept.
//    Shift of N: done in cycle k+N+1; busy for N+1 cycles.
//  i_start while busy (SHIFT or DONE) is ignored; no queuing.
//    i_mode and i_amount are don't-care outside the accept edge.
//  o_done and o_busy are registered (state-decoded); no combinational input-to-output paths.
// CONFIGURATION
//  Macro UNIV_SHIFT_PARITY_EN.
//  Defined: adds output port o_parity (1 bit) = XOR of the register.
//    Registered on the same edge as o_storedValue; reset 0.
//  Undefined: o_parity port and its logic are absent; all other behaviour is identical.
// STRUCTURE
//  Package univ_shift_pkg: mode_t enum (8 opcodes above) and state_t enum (IDLE/SHIFT/DONE).
//  Sub-module usr_step: combinational single-step unit.
//    Inputs: value, mode, fill bit. Outputs: next value, shifted-out bit.
//  Top level holds the FSM, counter and register.
// TESTING (WIDTH=8)
//  1 Start SHL 4, drop i_rst_n mid-shift -> immediately o_storedValue=0x00, o_busy=0,
//    no o_done pulse after release.
//  2 LOAD 0xA5 -> 0xA5 after accept edge; o_done high the next cycle; o_busy high 1 cycle.
//  3 LOAD 0x81, ROL amount 3 -> 0x0C after 3 shift edges; o_serial=0; o_done in cycle k+4.
//  4 LOAD 0x80, SHRA amount 9 -> clamps to 8, result 0xFF.
//    LOAD 0x80, SHR amount 8 with i_serial=0 -> result 0x00.
//  5 LOAD 0x01, SHL 4 (i_serial=0); assert i_start LOAD 0xFF during SHIFT -> ignored; final 0x10.
//  6 UNIV_SHIFT_PARITY_EN defined: LOAD 0x07 -> o_parity=1; LOAD 0x03 -> o_parity=0.
//    Undefined: build compiles with no o_parity port.

Source files
------------

// File: rtl/univ_shift_pkg.sv
// Shared types for the universal shift register: command opcodes and FSM states.
package univ_shift_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_LOAD  = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_SHR   = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_ROR   = 3'b101,
    MODE_SHRA  = 3'b110,
    MODE_CLEAR = 3'b111
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/usr_step.sv
// Combinational single-bit step: next register value and the bit that leaves it.
module usr_step
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  mode_t            mode,
  input  logic             fill,
  output logic [WIDTH-1:0] next_value,
  output logic             out_bit
);

  always_comb begin
    next_value = value;
    out_bit    = 1'b0;
    unique case (mode)
      MODE_SHL: begin
        next_value = {value[WIDTH-2:0], fill};
        out_bit    = value[WIDTH-1];
      end
      MODE_SHR: begin
        next_value = {fill, value[WIDTH-1:1]};
        out_bit    = value[0];
      end
      MODE_ROL: begin
        next_value = {value[WIDTH-2:0], value[WIDTH-1]};
        out_bit    = value[WIDTH-1];
      end
      MODE_ROR: begin
        next_value = {value[0], value[WIDTH-1:1]};
        out_bit    = value[0];
      end
      MODE_SHRA: begin
        next_value = {value[WIDTH-1], value[WIDTH-1:1]};
        out_bit    = value[0];
      end
      default: begin
        next_value = value;
        out_bit    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: load/clear/hold or N-step shift/rotate under busy/done.
// Optional macro UNIV_SHIFT_PARITY_EN adds a registered o_parity output.
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [2:0]       i_mode,
  input  logic [CNT_W-1:0] i_amount,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_serial,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_storedValue,
  output logic             o_serial
`ifdef UNIV_SHIFT_PARITY_EN
  ,
  output logic             o_parity
`endif
);

  localparam logic [CNT_W-1:0] MAX_AMT = CNT_W'(WIDTH);

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d, cmd;
  logic [CNT_W-1:0] cnt_q, cnt_d, amt;
  logic [WIDTH-1:0] reg_q, reg_d, step_val;
  logic             ser_q, ser_d, step_out;

  assign cmd = mode_t'(i_mode);
  assign amt = (i_amount > MAX_AMT) ? MAX_AMT : i_amount;

  usr_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .value     (reg_q),
    .mode      (mode_q),
    .fill      (i_serial),
    .next_value(step_val),
    .out_bit   (step_out)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    reg_d   = reg_q;
    ser_d   = ser_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          unique case (cmd)
            MODE_LOAD: begin
              reg_d   = i_data;
              state_d = ST_DONE;
            end
            MODE_CLEAR: begin
              reg_d   = '0;
              state_d = ST_DONE;
            end
            MODE_HOLD: state_d = ST_DONE;
            default: begin
              if (amt == '0) begin
                state_d = ST_DONE;
              end else begin
                mode_d  = cmd;
                cnt_d   = amt;
                state_d = ST_SHIFT;
              end
            end
          endcase
        end
      end
      // Counter holds the remaining steps; the last step is taken when it reads 1.
      ST_SHIFT: begin
        reg_d = step_val;
        ser_d = step_out;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_HOLD;
      cnt_q   <= '0;
      reg_q   <= '0;
      ser_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      reg_q   <= reg_d;
      ser_q   <= ser_d;
    end
  end

  assign o_busy        = (state_q != ST_IDLE);
  assign o_done        = (state_q == ST_DONE);
  assign o_storedValue = reg_q;
  assign o_serial      = ser_q;

`ifdef UNIV_SHIFT_PARITY_EN
  logic parity_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) parity_q <= 1'b0;
    else          parity_q <= ^reg_d;
  end

  assign o_parity = parity_q;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg (WIDTH=8): directed commands, done-driven checking.
module tb_univ_shift_reg;
  import univ_shift_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [2:0]       mode = 3'b000;
  logic [CNT_W-1:0] amount = '0;
  logic [WIDTH-1:0] data = '0;
  logic             ser_in = 1'b0;
  logic             busy, done, ser_out;
  logic [WIDTH-1:0] value;
`ifdef UNIV_SHIFT_PARITY_EN
  logic             parity;
`endif

  univ_shift_reg #(
    .WIDTH(WIDTH)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_mode       (mode),
    .i_amount     (amount),
    .i_data       (data),
    .i_serial     (ser_in),
    .o_busy       (busy),
    .o_done       (done),
    .o_storedValue(value),
    .o_serial     (ser_out)
`ifdef UNIV_SHIFT_PARITY_EN
    ,
    .o_parity     (parity)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] val;
    logic             ser;
    int               at_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse retires one queued expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_value", int'(value), int'(e.val));
        check("done_serial", int'(ser_out), int'(e.ser));
        check("done_cycle", cyc, e.at_cyc);
      end
    end
  end

  // Issue a command on the next edge; queue the result if it should complete.
  task automatic issue(input mode_t m, input int amt, input logic [WIDTH-1:0] d,
                       input logic fill, input logic [WIDTH-1:0] ev, input logic es,
                       input int n_steps, input bit push);
    exp_t e;
    @(negedge clk);
    start  = 1'b1;
    mode   = 3'(m);
    amount = CNT_W'(amt);
    data   = d;
    ser_in = fill;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e.val    = ev;
      e.ser    = es;
      e.at_cyc = cyc + n_steps;
      exp_q.push_back(e);
    end
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy) return;
      n++;
    end
    check("busy_timeout", n, -1);
  endtask

  int nb;

  initial begin
    #2;
    check("rst_value", int'(value), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_serial", int'(ser_out), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load: value visible right after accept, busy for exactly one cycle.
    issue(MODE_LOAD, 0, 8'hA5, 1'b0, 8'hA5, 1'b0, 0, 1'b1);
    check("load_value_at_accept", int'(value), 'hA5);
    count_busy(nb);
    check("load_busy_cycles", nb, 1);

    issue(MODE_CLEAR, 0, 8'h77, 1'b0, 8'h00, 1'b0, 0, 1'b1);
    count_busy(nb);
    issue(MODE_LOAD, 0, 8'h5A, 1'b0, 8'h5A, 1'b0, 0, 1'b1);
    count_busy(nb);
    issue(MODE_HOLD, 3, 8'hFF, 1'b1, 8'h5A, 1'b0, 0, 1'b1);
    count_busy(nb);
    issue(MODE_SHL, 0, 8'hFF, 1'b1, 8'h5A, 1'b0, 0, 1'b1);
    count_busy(nb);
    check("shift0_busy_cycles", nb, 1);

    // Rotate left 3 of 0x81.
    issue(MODE_LOAD, 0, 8'h81, 1'b0, 8'h81, 1'b0, 0, 1'b1);
    count_busy(nb);
    issue(MODE_ROL, 3, 8'h00, 1'b0, 8'h0C, 1'b0, 3, 1'b1);
    count_busy(nb);
    check("rol3_busy_cycles", nb, 4);

    // Amount clamp and full-width logical shift.
    issue(MODE_LOAD, 0, 8'h80, 1'b0, 8'h80, 1'b0, 0, 1'b1);
    count_busy(nb);
    issue(MODE_SHRA, 9, 8'h00, 1'b0, 8'hFF, 1'b1, 8, 1'b1);
    count_busy(nb);
    check("shra9_busy_cycles", nb, 9);
    issue(MODE_LOAD, 0, 8'h80, 1'b0, 8'h80, 1'b1, 0, 1'b1);
    count_busy(nb);
    issue(MODE_SHR, 8, 8'h00, 1'b0, 8'h00, 1'b1, 8, 1'b1);
    count_busy(nb);

    // Start during SHIFT must be ignored.
    issue(MODE_LOAD, 0, 8'h01, 1'b0, 8'h01, 1'b1, 0, 1'b1);
    count_busy(nb);
    issue(MODE_SHL, 4, 8'h00, 1'b0, 8'h10, 1'b0, 4, 1'b1);
    @(negedge clk);
    start = 1'b1;
    mode  = 3'(MODE_LOAD);
    data  = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    count_busy(nb);

    issue(MODE_ROR, 1, 8'h00, 1'b0, 8'h08, 1'b0, 1, 1'b1);
    count_busy(nb);
    issue(MODE_SHL, 2, 8'h00, 1'b1, 8'h23, 1'b0, 2, 1'b1);
    count_busy(nb);
    issue(MODE_SHR, 3, 8'h00, 1'b1, 8'hE4, 1'b0, 3, 1'b1);
    count_busy(nb);
    issue(MODE_ROL, 1, 8'h00, 1'b0, 8'hC9, 1'b1, 1, 1'b1);
    count_busy(nb);

    // Reset mid-shift aborts with no done pulse.
    issue(MODE_LOAD, 0, 8'h3C, 1'b0, 8'h3C, 1'b1, 0, 1'b1);
    count_busy(nb);
    issue(MODE_SHL, 4, 8'h00, 1'b1, 8'h00, 1'b0, 4, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_value", int'(value), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_serial", int'(ser_out), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_still_idle", int'(busy), 0);

    issue(MODE_LOAD, 0, 8'h07, 1'b0, 8'h07, 1'b0, 0, 1'b1);
`ifdef UNIV_SHIFT_PARITY_EN
    check("parity_07", int'(parity), 1);
`endif
    count_busy(nb);
    issue(MODE_LOAD, 0, 8'h03, 1'b0, 8'h03, 1'b0, 0, 1'b1);
`ifdef UNIV_SHIFT_PARITY_EN
    check("parity_03", int'(parity), 0);
`endif
    count_busy(nb);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("pending_expectations", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
